// File: rtl/lcd_bus_sequencer_if.sv
// Avalon-MM slave port of the LCD bus sequencer.
interface lcd_bus_sequencer_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/lcd_bus_sequencer.sv
// HD44780 8-bit bus cycle sequencer: stalls the Avalon master via waitrequest while it
// busy-polls the controller and then runs one correctly timed E cycle.
module lcd_bus_sequencer #(
  parameter int T_AS     = 3,
  parameter int T_PW     = 12,
  parameter int T_H      = 10,
  parameter int POLL_EN  = 1,
  parameter int POLL_MAX = 4096
) (
  input  logic                clk,
  input  logic                reset_n,
  lcd_bus_sequencer_if.slave  av,
  output logic                busy_timeout,
  output logic                LCD_E,
  output logic                LCD_RS,
  output logic                LCD_RW,
  inout  wire  [7:0]          LCD_data
);

  localparam int PH_A   = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int PH_MAX = (PH_A > T_H) ? PH_A : T_H;
  localparam int CW     = $clog2(PH_MAX + 1);
  localparam int PCW    = $clog2(POLL_MAX + 1);

  localparam logic [CW-1:0]  AS_M1 = CW'(T_AS - 1);
  localparam logic [CW-1:0]  PW_M1 = CW'(T_PW - 1);
  localparam logic [CW-1:0]  H_M1  = CW'(T_H - 1);
  localparam logic [PCW-1:0] PMAX  = PCW'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_SU, S_POLL_HI, S_POLL_HO, S_SU, S_HI, S_HO, S_DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [PCW-1:0] polls_q, polls_d;
  logic [1:0]     addr_q;
  logic [7:0]     wdata_q, rdata_q;
  logic           drive_q, d7_q, timeout_q, e_q, rs_q, rw_q;

  logic req, dir_ok, need_poll;

  assign req       = av.read | av.write;
  // read wins when both strobes are high; odd addresses are the read registers
  assign dir_ok    = av.read ? av.address[0] : ~av.address[0];
  assign need_poll = (POLL_EN != 0) && !(av.read && (av.address == 2'd1));
  assign polls_d   = polls_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      polls_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      drive_q   <= 1'b0;
      d7_q      <= 1'b0;
      timeout_q <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          addr_q  <= av.address;
          wdata_q <= av.writedata;
          if (!dir_ok) begin
            if (av.read) rdata_q <= '0;
            state_q <= S_DONE;
          end else if (need_poll) begin
            state_q <= S_POLL_SU;
            cnt_q   <= AS_M1;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            drive_q <= 1'b0;
          end else begin
            state_q <= S_SU;
            cnt_q   <= AS_M1;
            rs_q    <= av.address[1];
            rw_q    <= av.address[0];
            drive_q <= ~av.address[0];
          end
        end
        S_POLL_SU:
          if (cnt_q == '0) begin
            state_q <= S_POLL_HI;
            cnt_q   <= PW_M1;
            e_q     <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        S_POLL_HI:
          if (cnt_q == '0) begin
            d7_q    <= LCD_data[7];
            state_q <= S_POLL_HO;
            cnt_q   <= H_M1;
            e_q     <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        S_POLL_HO:
          if (cnt_q == '0) begin
            polls_q <= polls_d;
            cnt_q   <= AS_M1;
            if (d7_q && (polls_d != PMAX)) begin
              state_q <= S_POLL_SU;
            end else begin
              // give up on a stuck controller but still perform the access
              if (d7_q) timeout_q <= 1'b1;
              state_q <= S_SU;
              rs_q    <= addr_q[1];
              rw_q    <= addr_q[0];
              drive_q <= ~addr_q[0];
            end
          end else cnt_q <= cnt_q - 1'b1;
        S_SU:
          if (cnt_q == '0) begin
            state_q <= S_HI;
            cnt_q   <= PW_M1;
            e_q     <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        S_HI:
          if (cnt_q == '0) begin
            if (rw_q) rdata_q <= LCD_data;
            state_q <= S_HO;
            cnt_q   <= H_M1;
            e_q     <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        S_HO:
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            rs_q    <= 1'b0;
            rw_q    <= 1'b1;
            drive_q <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        S_DONE: begin
          state_q <= S_IDLE;
          polls_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LCD_data       = (drive_q && !rw_q) ? wdata_q : 8'bz;
  assign LCD_E          = e_q;
  assign LCD_RS         = rs_q;
  assign LCD_RW         = rw_q;
  assign busy_timeout   = timeout_q;
  assign av.readdata    = rdata_q;
  assign av.waitrequest = req & (state_q != S_DONE);

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with a small HD44780 bus model per instance.
module tb_lcd_bus_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int checks = 0;
  int failures = 0;

  lcd_bus_sequencer_if bus();
  lcd_bus_sequencer_if bus2();

  logic       lcd_e, lcd_rs, lcd_rw, busy_to;
  wire  [7:0] lcd_data;
  logic       lcd_e2, lcd_rs2, lcd_rw2, busy_to2;
  wire  [7:0] lcd_data2;

  lcd_bus_sequencer dut (
    .clk(clk), .reset_n(reset_n), .av(bus), .busy_timeout(busy_to),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_data(lcd_data)
  );

  lcd_bus_sequencer #(.POLL_MAX(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .av(bus2), .busy_timeout(busy_to2),
    .LCD_E(lcd_e2), .LCD_RS(lcd_rs2), .LCD_RW(lcd_rw2), .LCD_data(lcd_data2)
  );

  // main LCD model: busy for the first busy_set polls after poll_base
  int n_poll = 0, n_acc = 0, e_run = 0, pw_last = 0, rw_low = 0;
  int busy_set = 0, poll_base = 0;
  logic       acc_rs = 1'b0, acc_rw = 1'b0;
  logic [7:0] acc_data = 8'h00;
  logic [7:0] stat_lo = 8'h00, model_val;

  assign model_val = lcd_rs ? 8'h00 : (stat_lo | (((n_poll - poll_base) < busy_set) ? 8'h80 : 8'h00));
  assign lcd_data  = lcd_rw ? model_val : 8'bz;

  always @(negedge clk) begin
    if (lcd_e) e_run++; else e_run = 0;
    if (!lcd_rw) rw_low++;
  end

  always @(negedge lcd_e) begin
    if (lcd_rw && !lcd_rs) n_poll++;
    else begin
      n_acc++;
      acc_rs   = lcd_rs;
      acc_rw   = lcd_rw;
      acc_data = lcd_data;
      pw_last  = e_run;
    end
  end

  // second model: permanently busy, data register reads 0x3C
  int n_poll2 = 0;
  assign lcd_data2 = lcd_rw2 ? (lcd_rs2 ? 8'h3C : 8'h80) : 8'bz;
  always @(negedge lcd_e2) if (lcd_rw2 && !lcd_rs2) n_poll2++;

  task automatic run_req(input logic [1:0] a, input logic rd, input logic wr,
                         input logic [7:0] wd, input int budget, output int lat);
    @(negedge clk);
    bus.address = a; bus.read = rd; bus.write = wr; bus.writedata = wd;
    #1;
    lat = 0;
    while (bus.waitrequest && lat < budget) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drop_req();
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.address = 2'd0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = 8'h00;
    bus2.address = 2'd0; bus2.read = 1'b0; bus2.write = 1'b0; bus2.writedata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL reset_e got %b want 0", lcd_e); end
    checks++; if (lcd_rs !== 1'b0) begin failures++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b1) begin failures++; $display("FAIL reset_rw got %b want 1", lcd_rw); end
    checks++; if (bus.readdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got %h want 00", bus.readdata); end
    checks++; if (busy_to !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b want 0", busy_to); end
    checks++; if (busy_to2 !== 1'b0) begin failures++; $display("FAIL reset_timeout2 got %b want 0", busy_to2); end
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL reset_wait got %b want 0", bus.waitrequest); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cmd_write();
    int lat, bp, ba;
    busy_set = 0; poll_base = n_poll; stat_lo = 8'h00;
    bp = n_poll; ba = n_acc;
    run_req(2'd0, 1'b0, 1'b1, 8'h38, 200, lat);
    checks++; if (lat !== 51) begin failures++; $display("FAIL cmd_latency got %0d want 51", lat); end
    checks++; if (n_poll - bp !== 1) begin failures++; $display("FAIL cmd_polls got %0d want 1", n_poll - bp); end
    checks++; if (n_acc - ba !== 1) begin failures++; $display("FAIL cmd_access got %0d want 1", n_acc - ba); end
    checks++; if (acc_rs !== 1'b0 || acc_rw !== 1'b0) begin failures++; $display("FAIL cmd_rsrw got %b%b want 00", acc_rs, acc_rw); end
    checks++; if (acc_data !== 8'h38) begin failures++; $display("FAIL cmd_data got %h want 38", acc_data); end
    checks++; if (pw_last !== 12) begin failures++; $display("FAIL cmd_e_width got %0d want 12", pw_last); end
    drop_req();
    @(negedge clk);
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL cmd_idle_wait got %b want 0", bus.waitrequest); end
    checks++; if (lcd_rw !== 1'b1) begin failures++; $display("FAIL cmd_rw_release got %b want 1", lcd_rw); end
  endtask

  task automatic test_status_read();
    int lat, bp, ba, rwl;
    stat_lo = 8'hA5; busy_set = 0; poll_base = n_poll;
    bp = n_poll; ba = n_acc; rwl = rw_low;
    run_req(2'd1, 1'b1, 1'b0, 8'h00, 200, lat);
    checks++; if (lat !== 26) begin failures++; $display("FAIL status_latency got %0d want 26", lat); end
    checks++; if (bus.readdata !== 8'hA5) begin failures++; $display("FAIL status_rdata got %h want a5", bus.readdata); end
    checks++; if ((n_poll - bp) + (n_acc - ba) !== 1) begin failures++; $display("FAIL status_pulses got %0d want 1", (n_poll - bp) + (n_acc - ba)); end
    checks++; if (rw_low !== rwl) begin failures++; $display("FAIL status_rw_low got %0d want %0d", rw_low, rwl); end
    drop_req();
    stat_lo = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_busy_write();
    int lat, bp, ba;
    busy_set = 3; poll_base = n_poll;
    bp = n_poll; ba = n_acc;
    run_req(2'd2, 1'b0, 1'b1, 8'h41, 400, lat);
    checks++; if (lat !== 126) begin failures++; $display("FAIL busy_latency got %0d want 126", lat); end
    checks++; if (n_poll - bp !== 4) begin failures++; $display("FAIL busy_polls got %0d want 4", n_poll - bp); end
    checks++; if (n_acc - ba !== 1) begin failures++; $display("FAIL busy_access got %0d want 1", n_acc - ba); end
    checks++; if (acc_rs !== 1'b1 || acc_rw !== 1'b0) begin failures++; $display("FAIL busy_rsrw got %b%b want 10", acc_rs, acc_rw); end
    checks++; if (acc_data !== 8'h41) begin failures++; $display("FAIL busy_data got %h want 41", acc_data); end
    checks++; if (busy_to !== 1'b0) begin failures++; $display("FAIL busy_timeout got %b want 0", busy_to); end
    drop_req();
    busy_set = 0;
    @(negedge clk);
  endtask

  task automatic test_mismatch();
    int lat, bp, ba;
    bp = n_poll; ba = n_acc;
    run_req(2'd1, 1'b0, 1'b1, 8'h55, 10, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_write_latency got %0d want 1", lat); end
    drop_req();
    run_req(2'd0, 1'b1, 1'b0, 8'h00, 10, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_read_latency got %0d want 1", lat); end
    checks++; if (bus.readdata !== 8'h00) begin failures++; $display("FAIL mis_read_rdata got %h want 00", bus.readdata); end
    drop_req();
    repeat (3) @(negedge clk);
    checks++; if ((n_poll - bp) + (n_acc - ba) !== 0) begin failures++; $display("FAIL mis_pulses got %0d want 0", (n_poll - bp) + (n_acc - ba)); end
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL mis_idle_wait got %b want 0", bus.waitrequest); end
  endtask

  task automatic test_timeout();
    int lat;
    @(negedge clk);
    bus2.address = 2'd3; bus2.read = 1'b1; bus2.write = 1'b0;
    #1;
    lat = 0;
    while (bus2.waitrequest && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 76) begin failures++; $display("FAIL to_latency got %0d want 76", lat); end
    checks++; if (busy_to2 !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", busy_to2); end
    checks++; if (bus2.readdata !== 8'h3C) begin failures++; $display("FAIL to_rdata got %h want 3c", bus2.readdata); end
    checks++; if (n_poll2 !== 2) begin failures++; $display("FAIL to_polls got %0d want 2", n_poll2); end
    bus2.read = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_to2 !== 1'b1) begin failures++; $display("FAIL to_sticky got %b want 1", busy_to2); end
  endtask

  task automatic test_reset_mid();
    int k, ba;
    stat_lo = 8'h6C; busy_set = 0; poll_base = n_poll;
    @(negedge clk);
    bus.address = 2'd0; bus.read = 1'b0; bus.write = 1'b1; bus.writedata = 8'h38;
    k = 0;
    while (!(lcd_e && !lcd_rw) && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 200) begin failures++; $display("FAIL mid_reach_hi got %0d want <200", k); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (lcd_e !== 1'b0) begin failures++; $display("FAIL mid_e got %b want 0", lcd_e); end
    checks++; if (lcd_rw !== 1'b1) begin failures++; $display("FAIL mid_rw got %b want 1", lcd_rw); end
    checks++; if (lcd_data !== 8'h6C) begin failures++; $display("FAIL mid_bus got %h want 6c", lcd_data); end
    checks++; if (bus.waitrequest !== 1'b1) begin failures++; $display("FAIL mid_wait_held got %b want 1", bus.waitrequest); end
    drop_req();
    #1;
    checks++; if (bus.waitrequest !== 1'b0) begin failures++; $display("FAIL mid_wait_drop got %b want 0", bus.waitrequest); end
    @(negedge clk);
    reset_n = 1'b1;
    ba = n_acc;
    repeat (5) @(negedge clk);
    checks++; if (n_acc !== ba || lcd_e !== 1'b0) begin failures++; $display("FAIL mid_no_resume got acc+%0d e=%b want acc+0 e=0", n_acc - ba, lcd_e); end
    stat_lo = 8'h00;
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_status_read();
    test_busy_write();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
